alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 107 ++++++++++
 tb/tb_alu.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: 4-bit registered ALU with one-cycle latency and full throughput.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid        operands/op are valid this cycle
//   a, b            4-bit operands (b is ignored for shift ops)
//   op              000 ADD, 001 SUB, 010 AND, 011 OR, 100 SHL, 101 SHR,
//                   110/111 reserved (result 0)
//   out_valid       result/flags were loaded on the last edge
//   result          4-bit result
//   carry           ADD carry-out / SUB borrow
//   zero, negative  result == 0, result[3]
//   overflow        signed overflow (ADD/SUB only)
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  a,
    input  logic [3:0]  b,
    input  logic [2:0]  op,
    output logic        out_valid,
    output logic [3:0]  result,
    output logic        carry,
    output logic        zero,
    output logic        negative,
    output logic        overflow
);

    localparam int unsigned W = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b101
    } op_e;

    logic         valid_q;
    logic [W-1:0] result_q, result_d;
    logic         carry_q, carry_d;
    logic         zero_q, zero_d;
    logic         negative_q, negative_d;
    logic         overflow_q, overflow_d;

    logic [W:0]   sum_c;
    logic [W:0]   diff_c;

    // One extra bit on each side so bit W carries the carry-out / borrow.
    assign sum_c  = {1'b0, a} + {1'b0, b};
    assign diff_c = {1'b0, a} - {1'b0, b};

    // Next result and flags for the presented operation.
    always_comb begin
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        case (op)
            OP_ADD: begin
                result_d   = sum_c[W-1:0];
                carry_d    = sum_c[W];
                overflow_d = (a[W-1] == b[W-1]) && (sum_c[W-1] != a[W-1]);
            end
            OP_SUB: begin
                result_d   = diff_c[W-1:0];
                carry_d    = diff_c[W];
                overflow_d = (a[W-1] != b[W-1]) && (diff_c[W-1] != a[W-1]);
            end
            OP_AND:  result_d = a & b;
            OP_OR:   result_d = a | b;
            OP_SHL:  result_d = {a[W-2:0], 1'b0};
            OP_SHR:  result_d = {1'b0, a[W-1:1]};
            default: result_d = '0;
        endcase
        zero_d     = (result_d == '0);
        negative_d = result_d[W-1];
    end

    // Output registers; data holds while no valid input arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                result_q   <= result_d;
                carry_q    <= carry_d;
                zero_q     <= zero_d;
                negative_q <= negative_d;
                overflow_q <= overflow_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign negative  = negative_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu.
// Ports: none (drives clk/rst/in_valid/a/b/op, observes all alu outputs).
module tb_alu;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       negative;
    logic       overflow;

    int checks;
    int passes;

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs mid-cycle, then sample 1 time unit after the next rising edge.
    task automatic step(input logic r, input logic v, input logic [2:0] o,
                        input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        op       = o;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
    endtask

    // Compare {out_valid, result, carry, zero, negative, overflow}.
    task automatic check(input string tag, input logic ev, input logic [3:0] er,
                         input logic ec, input logic ez, input logic en, input logic eo);
        logic [8:0] got;
        logic [8:0] exp;
        got = {out_valid, result, carry, zero, negative, overflow};
        exp = {ev, er, ec, ez, en, eo};
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: observed v=%b r=%b c=%b z=%b n=%b o=%b expected v=%b r=%b c=%b z=%b n=%b o=%b",
                    tag, got[8], got[7:4], got[3], got[2], got[1], got[0],
                    exp[8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 3'b000;
        a        = 4'h0;
        b        = 4'h0;

        step(1'b1, 1'b0, 3'b000, 4'h0, 4'h0);
        step(1'b1, 1'b0, 3'b000, 4'h0, 4'h0);
        check("reset", 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back valid vectors, each checked one cycle after issue.
        step(1'b0, 1'b1, 3'b000, 4'b0101, 4'b0011);
        check("add_5_3",   1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 3'b000, 4'b1111, 4'b0001);
        check("add_f_1",   1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b000, 4'b1111, 4'b1111);
        check("add_f_f",   1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'b000, 4'b0111, 4'b0001);
        check("add_7_1",   1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 3'b000, 4'b1000, 4'b1000);
        check("add_8_8",   1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 3'b001, 4'b0110, 4'b0011);
        check("sub_6_3",   1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b001, 4'b0000, 4'b0001);
        check("sub_0_1",   1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'b001, 4'b1111, 4'b1111);
        check("sub_f_f",   1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b001, 4'b1000, 4'b0001);
        check("sub_8_1",   1'b1, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 3'b001, 4'b0011, 4'b1000);
        check("sub_3_8",   1'b1, 4'b1011, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 3'b010, 4'b1100, 4'b1010);
        check("and_c_a",   1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'b010, 4'b0101, 4'b1010);
        check("and_5_a",   1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b011, 4'b0101, 4'b1010);
        check("or_5_a",    1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'b100, 4'b0101, 4'b1111);
        check("shl_5",     1'b1, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'b100, 4'b1001, 4'b0000);
        check("shl_9",     1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b101, 4'b0101, 4'b1111);
        check("shr_5",     1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b101, 4'b1000, 4'b0000);
        check("shr_8",     1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b101, 4'b0001, 4'b0000);
        check("shr_1",     1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b110, 4'b1111, 4'b1111);
        check("rsv_110",   1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b111, 4'b0111, 4'b1000);
        check("rsv_111",   1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);

        // Single pulse: output valid for one cycle, data then holds.
        step(1'b0, 1'b1, 3'b000, 4'b0101, 4'b0011);
        check("pulse",     1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 3'b000, 4'b1111, 4'b0001);
        check("hold_1",    1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 3'b001, 4'b0000, 4'b0001);
        check("hold_2",    1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset wins over a valid operation presented in the same cycle.
        step(1'b1, 1'b1, 3'b000, 4'b1111, 4'b1111);
        check("rst_prio",  1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'b000, 4'b1111, 4'b1111);
        check("rst_idle",  1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b000, 4'b0001, 4'b0001);
        check("post_rst",  1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a stream clears on that edge.
        step(1'b0, 1'b1, 3'b001, 4'b0000, 4'b0001);
        check("stream",    1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3'b011, 4'b0101, 4'b1010);
        check("mid_rst",   1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'b010, 4'b1100, 4'b1010);
        check("resume",    1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'b000, 4'b0000, 4'b0000);
        check("tail_hold", 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
